// File: rtl/xrv_pkg.sv
// rtl/xrv_pkg.sv - shared types and helpers for the xrv data-memory responder
package xrv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } xrv_dmem_state_t;

  // Bit n set means byte-enable pattern n is legal: 1,2,3,4,8,C,F
  localparam logic [15:0] LEGAL_BE_MASK = 16'h911E;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xrv_dmem_ram.sv
// rtl/xrv_dmem_ram.sv - DEPTH x 32 single-port synchronous RAM with byte write enables
module xrv_dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents and the read register are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/xrv_dmem.sv
// rtl/xrv_dmem.sv - d_* load/store responder; optional XRV_DMEM_BE_CHK_EN byte-enable legality check
module xrv_dmem
  import xrv_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  output logic        d_err
);

  localparam int          AW        = idx_width(DEPTH);
  localparam logic [31:0] SPAN_MASK = 32'(4 * DEPTH - 1);
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  xrv_dmem_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, err_q, rd_zero_q;
  logic [3:0]      be_q;
  logic [31:0]     data_q;
  logic [AW-1:0]   idx_q;

  logic            req, accept, in_range, be_ok, acc_err;
  logic            ram_re;
  logic [3:0]      ram_we;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_rdata;

  assign req      = d_wr_req | d_rd_req;
  assign accept   = (state_q == IDLE) && req;
  assign in_range = (d_addr & ~SPAN_MASK) == BASE_ADDR;

`ifdef XRV_DMEM_BE_CHK_EN
  assign be_ok = LEGAL_BE_MASK[d_be];
`else
  assign be_ok = 1'b1;
`endif

  assign acc_err = !in_range || !be_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_wr_ready = 1'b0;
    d_rd_ready = 1'b0;
    d_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        d_wr_ready = wr_q;
        d_rd_ready = !wr_q;
        d_err      = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
      be_q      <= 4'd0;
      data_q    <= 32'd0;
      idx_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= d_wr_req;
        err_q  <= acc_err;
        be_q   <= d_be;
        data_q <= d_wr_data;
        idx_q  <= d_addr[AW+1:2];
        if (!d_wr_req) rd_zero_q <= !in_range;
      end
    end
  end

  // Reads address the RAM straight from d_addr at acceptance; writes use the latched index in RESP.
  assign ram_re    = accept && !d_wr_req;
  assign ram_we    = (state_q == RESP && wr_q && !err_q && rstb) ? be_q : 4'd0;
  assign ram_addr  = (state_q == RESP) ? idx_q : d_addr[AW+1:2];
  assign d_rd_data = rd_zero_q ? 32'd0 : ram_rdata;

  xrv_dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_xrv_dmem.sv
// tb/tb_xrv_dmem.sv - scoreboard bench for xrv_dmem against a word-array reference model
module tb_xrv_dmem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WS    = 2;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_wr_req = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wr_data = '0;
  logic        d_wr_ready;
  logic        d_rd_req = 1'b0;
  logic        d_rd_ready;
  logic [31:0] d_rd_data;
  logic        d_err;

  xrv_dmem #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) u_dut (
    .clk        (clk),
    .rstb       (rstb),
    .d_addr     (d_addr),
    .d_wr_req   (d_wr_req),
    .d_be       (d_be),
    .d_wr_data  (d_wr_data),
    .d_wr_ready (d_wr_ready),
    .d_rd_req   (d_rd_req),
    .d_rd_ready (d_rd_ready),
    .d_rd_data  (d_rd_data),
    .d_err      (d_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    int          cyc;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_acc = -10;
  int          rst_cyc = -10;
  bit          mon_on = 1'b0;
  logic [31:0] prev_rd;
  exp_t        me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit be_legal(input logic [3:0] be);
    return be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the edge ending the ready cycle.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data);
    exp_t e;
    bit   err;
    bit   seen;
    int   w;
    err = !addr_ok(addr);
`ifdef XRV_DMEM_BE_CHK_EN
    if (!be_legal(be)) err = 1'b1;
`endif
    w = addr_ok(addr) ? int'((addr - BASE) >> 2) : 0;
    e.wr   = wr;
    e.cyc  = cyc + 1 + WS;
    e.err  = err;
    e.data = 32'd0;
    if (wr) begin
      if (!err) begin
        logic [31:0] word;
        word = model.exists(w) ? model[w] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = data[8*i +: 8];
        model[w] = word;
      end
    end else begin
      e.data = addr_ok(addr) ? model[w] : 32'd0;
      rd_acc = cyc;
    end
    d_addr    = addr;
    d_be      = be;
    d_wr_data = data;
    d_wr_req  = wr;
    d_rd_req  = !wr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    d_addr    = $urandom;
    d_be      = 4'($urandom);
    d_wr_data = $urandom;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (d_rd_ready || d_wr_ready) seen = 1'b1;
    end
    chk("ready_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    d_wr_req = 1'b0;
    d_rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (d_rd_data !== prev_rd)
        chk("rd_data_stable", 32'(cyc == rd_acc + 1 || cyc == rst_cyc + 1), 32'd1);
      if (d_rd_ready || d_wr_ready) begin
        if (sb.size() == 0) begin
          chk("ready_without_request", 32'(sb.size()), 32'd1);
        end else begin
          me = sb.pop_front();
          chk("ready_kind", {30'd0, d_wr_ready, d_rd_ready}, me.wr ? 32'd2 : 32'd1);
          chk("ready_cycle", 32'(cyc), 32'(me.cyc));
          chk("err", 32'(d_err), 32'(me.err));
          if (!me.wr) chk("rd_data", d_rd_data, me.data);
        end
      end else begin
        chk("err_outside_ready", 32'(d_err), 32'd0);
      end
    end
    prev_rd = d_rd_data;
  end

  initial begin
    logic [31:0] addr;
    int          sel;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_ready", 32'(d_wr_ready), 32'd0);
    chk("reset_rd_ready", 32'(d_rd_ready), 32'd0);
    chk("reset_rd_data", d_rd_data, 32'd0);
    chk("reset_err", 32'(d_err), 32'd0);
    @(posedge clk);
    #1;
    rstb    = 1'b1;
    prev_rd = d_rd_data;
    mon_on  = 1'b1;

    do_req(1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_0000);
    do_req(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);

    do_req(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344);
    do_req(1'b1, 32'h0000_0020, 4'h4, 32'h00AA_0000);
    do_req(1'b0, 32'h0000_0020, 4'hF, 32'h0);

    do_req(1'b1, 32'h0000_1000, 4'hF, 32'h0000_0055);
    do_req(1'b0, 32'h0000_0000, 4'hF, 32'h0);
    do_req(1'b0, 32'h0000_1000, 4'hF, 32'h0);

    // Abort a write while it sits in WAIT: no ready, memory keeps the old word.
    do_req(1'b1, 32'h0000_0030, 4'hF, 32'h0BAD_F00D);
    d_addr    = 32'h0000_0030;
    d_be      = 4'hF;
    d_wr_data = 32'h1234_5678;
    d_wr_req  = 1'b1;
    @(posedge clk);
    #1;
    rstb     = 1'b0;
    d_wr_req = 1'b0;
    rst_cyc  = cyc;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    do_req(1'b0, 32'h0000_0030, 4'hF, 32'h0);

    do_req(1'b1, 32'h0000_0040, 4'hF, 32'hA5A5_A5A5);
    do_req(1'b1, 32'h0000_0040, 4'h6, 32'h1122_3344);
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0);

    for (int i = 0; i < 16; i++) do_req(1'b1, 32'h100 + 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) addr = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      else if (sel == 1) addr = 32'hFFFF_FFFC;
      else addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      do_req(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
